// File: rtl/uart_wb_slave.sv
// Wishbone B4 classic register front-end for the UART core: DATA/STATUS/CTRL/BAUD
// registers plus TX and RX byte FIFOs.
//   state | meaning
//   IDLE  | waiting for cyc & stb; an access is accepted and committed here
//   RESP  | termination cycle; no new request is accepted
module uart_wb_slave #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [15:0] baud_div_o,
  output logic        enable_o,
  output logic        irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state;
  logic          ack_q, err_q;
  logic [31:0]   dat_q;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_ovf, rx_ovf;
  logic [2:0]    ctrl;
  logic [15:0]   baud;
  logic          irq;

  logic          accept, bad, ok, wr_acc;
  logic [1:0]    reg_sel;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          wr_data, wr_stat, wr_ctrl, wr_baud, rd_data;
  logic          tx_pop, tx_push, tx_drop;
  logic          rx_in, rx_pop, rx_push, rx_drop;
  logic [31:0]   status, rd_val;
  logic          unused_bits;

  assign unused_bits = ^{wb_adr_i[31:5], wb_dat_i[31:16], wb_sel_i[3:2]};

  assign accept  = (state == IDLE) && wb_cyc_i && wb_stb_i;
  assign bad     = (wb_adr_i[1:0] != 2'b00) || wb_adr_i[4];
  assign ok      = accept && !bad;
  assign wr_acc  = ok && wb_we_i;
  assign reg_sel = wb_adr_i[3:2];

  assign wr_data = wr_acc && (reg_sel == 2'd0) && wb_sel_i[0];
  assign wr_stat = wr_acc && (reg_sel == 2'd1) && wb_sel_i[0];
  assign wr_ctrl = wr_acc && (reg_sel == 2'd2) && wb_sel_i[0];
  assign wr_baud = wr_acc && (reg_sel == 2'd3);
  assign rd_data = ok && !wb_we_i && (reg_sel == 2'd0);

  assign tx_full  = (tx_count == FULL);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == FULL);
  assign rx_empty = (rx_count == '0);

  assign tx_valid_o = !tx_empty && ctrl[0];
  assign tx_data_o  = tx_mem[tx_rd];
  assign tx_pop     = tx_valid_o && tx_ready_i;
  // A same-cycle pop frees the slot, so a write to a full FIFO still lands
  assign tx_drop    = wr_data && tx_full && !tx_pop;
  assign tx_push    = wr_data && !tx_drop;

  assign rx_pop  = rd_data && !rx_empty;
  assign rx_in   = rx_valid_i && ctrl[0];
  assign rx_drop = rx_in && rx_full && !rx_pop;
  assign rx_push = rx_in && !rx_drop;

  assign status = {8'b0, 8'(rx_count), 8'(tx_count), 2'b0,
                   rx_ovf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      2'd0:    if (!rx_empty) rd_val = {23'b0, 1'b1, rx_mem[rx_rd]};
      2'd1:    rd_val = status;
      2'd2:    rd_val = {29'b0, ctrl};
      default: rd_val = {16'b0, baud};
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= RESP;
          ack_q <= !bad;
          err_q <= bad;
          dat_q <= (!bad && !wb_we_i) ? rd_val : 32'b0;
        end
        RESP: begin
          state <= IDLE;
          ack_q <= 1'b0;
          err_q <= 1'b0;
          dat_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Terminations are qualified by the live strobe so an aborted access stays silent
  assign wb_ack_o = ack_q && wb_cyc_i && wb_stb_i;
  assign wb_err_o = err_q && wb_cyc_i && wb_stb_i;
  assign wb_dat_o = wb_ack_o ? dat_q : 32'b0;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) tx_mem[i] <= 8'h00;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr] <= wb_dat_i[7:0];
        tx_wr         <= tx_wr + 1'b1;
      end
      if (tx_pop) tx_rd <= tx_rd + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (rx_push) rx_mem[rx_wr] <= rx_data_i;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  // A new overflow wins over a clear in the same cycle so the event is not lost
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
      ctrl   <= '0;
      baud   <= DIV_RESET;
      irq    <= 1'b0;
    end else begin
      if (tx_drop)                     tx_ovf <= 1'b1;
      else if (wr_stat && wb_dat_i[4]) tx_ovf <= 1'b0;
      if (rx_drop)                     rx_ovf <= 1'b1;
      else if (wr_stat && wb_dat_i[5]) rx_ovf <= 1'b0;
      if (wr_ctrl) ctrl <= wb_dat_i[2:0];
      if (wr_baud && wb_sel_i[0]) baud[7:0]  <= wb_dat_i[7:0];
      if (wr_baud && wb_sel_i[1]) baud[15:8] <= wb_dat_i[15:8];
      irq <= (ctrl[1] && tx_empty) || (ctrl[2] && !rx_empty) || tx_ovf || rx_ovf;
    end
  end

  assign baud_div_o = baud;
  assign enable_o   = ctrl[0];
  assign irq_o      = irq;

endmodule

// File: tb/tb_uart_wb_slave.sv
// Self-checking bench for uart_wb_slave: scenario tasks with queue-based expected values.
module tb_uart_wb_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat_in = '0;
  logic [31:0] wb_dat_o;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        wb_ack_o, wb_err_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [15:0] baud_div_o;
  logic        enable_o, irq_o;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] rdat, exp;
  logic        ack, err;
  logic [7:0]  exp_b;

  uart_wb_slave #(.FIFO_DEPTH(16), .DIV_RESET(16'd434)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_in), .wb_dat_o(wb_dat_o),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .baud_div_o(baud_div_o), .enable_o(enable_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                     input logic rxp, input logic [7:0] rxd,
                     output logic [31:0] rd, output logic ak, output logic er);
    @(negedge clk);
    adr = a; we = w; dat_in = d; sel = s; cyc = 1'b1; stb = 1'b1;
    rx_valid = rxp; rx_data = rxd;
    @(posedge clk); #1;
    rd = wb_dat_o; ak = wb_ack_o; er = wb_err_o;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r; logic k, e;
    bus(a, 1'b1, d, s, 1'b0, 8'h00, r, k, e);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r, output logic k);
    logic e;
    bus(a, 1'b0, 32'h0, 4'hF, 1'b0, 8'h00, r, k, e);
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_checks++; if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_term: ack %b err %b, expected 0 0", wb_ack_o, wb_err_o); end
    n_checks++; if (wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h expected 0", wb_dat_o); end
    n_checks++; if (irq_o !== 1'b0 || enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq_en: irq %b en %b, expected 0 0", irq_o, enable_o); end
    n_checks++; if (tx_valid_o !== 1'b0 || tx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_tx: valid %b data %h, expected 0 00", tx_valid_o, tx_data_o); end
    n_checks++; if (baud_div_o !== 16'd434) begin n_fail++; $display("FAIL reset_baud: got %h expected %h", baud_div_o, 16'd434); end
    exp_q.push_back(32'h0000_000A);
    rd(32'h4, rdat, ack);
    exp = exp_q.pop_front();
    n_checks++; if (rdat !== exp || ack !== 1'b1) begin n_fail++; $display("FAIL reset_status: got %h ack %b, expected %h ack 1", rdat, ack, exp); end
  endtask

  task automatic test_tx_stream;
    wr(32'h8, 32'h1, 4'hF);
    wr(32'h0, 32'h41, 4'h1); tx_q.push_back(8'h41);
    wr(32'h0, 32'h42, 4'h1); tx_q.push_back(8'h42);
    n_checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h41) begin n_fail++; $display("FAIL tx_head: valid %b data %h, expected 1 41", tx_valid_o, tx_data_o); end
    exp_q.push_back(32'h0000_0208);
    rd(32'h4, rdat, ack);
    exp = exp_q.pop_front();
    n_checks++; if (rdat !== exp) begin n_fail++; $display("FAIL tx_status_2: got %h expected %h", rdat, exp); end
    tx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_b = tx_q.pop_front();
      n_checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== exp_b) begin n_fail++; $display("FAIL tx_pop_%0d: valid %b data %h, expected 1 %h", i, tx_valid_o, tx_data_o, exp_b); end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL tx_drained: valid %b expected 0", tx_valid_o); end
    exp_q.push_back(32'h0000_000A);
    rd(32'h4, rdat, ack);
    exp = exp_q.pop_front();
    n_checks++; if (rdat !== exp) begin n_fail++; $display("FAIL tx_status_empty: got %h expected %h", rdat, exp); end
  endtask

  task automatic test_tx_overflow;
    for (int i = 0; i < 16; i++) begin
      wr(32'h0, 32'h80 + i, 4'h1);
      tx_q.push_back(8'(8'h80 + i));
    end
    bus(32'h0, 1'b1, 32'hEE, 4'h1, 1'b0, 8'h00, rdat, ack, err);
    n_checks++; if (ack !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL tx_ovf_ack: ack %b err %b, expected 1 0", ack, err); end
    exp_q.push_back(32'h0000_1019);
    rd(32'h4, rdat, ack);
    exp = exp_q.pop_front();
    n_checks++; if (rdat !== exp) begin n_fail++; $display("FAIL tx_ovf_status: got %h expected %h", rdat, exp); end
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL tx_ovf_irq: got %b expected 1", irq_o); end
    wr(32'h4, 32'h10, 4'h1);
    exp_q.push_back(32'h0000_1009);
    rd(32'h4, rdat, ack);
    exp = exp_q.pop_front();
    n_checks++; if (rdat !== exp) begin n_fail++; $display("FAIL tx_ovf_clear: got %h expected %h", rdat, exp); end
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL tx_ovf_irq_clear: got %b expected 0", irq_o); end
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_b = tx_q.pop_front();
      n_checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== exp_b) begin n_fail++; $display("FAIL tx_full_drain_%0d: valid %b data %h, expected 1 %h", i, tx_valid_o, tx_data_o, exp_b); end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL tx_dropped_byte: valid %b data %h, expected empty", tx_valid_o, tx_data_o); end
  endtask

  task automatic test_rx;
    rx_push(8'h55);
    exp_q.push_back(32'h0000_0155);
    exp_q.push_back(32'h0000_0000);
    for (int i = 0; i < 2; i++) begin
      rd(32'h0, rdat, ack);
      exp = exp_q.pop_front();
      n_checks++; if (rdat !== exp || ack !== 1'b1) begin n_fail++; $display("FAIL rx_read_%0d: got %h ack %b, expected %h ack 1", i, rdat, ack, exp); end
    end
    for (int i = 0; i < 17; i++) rx_push(8'(8'h60 + i));
    exp_q.push_back(32'h0010_0026);
    rd(32'h4, rdat, ack);
    exp = exp_q.pop_front();
    n_checks++; if (rdat !== exp) begin n_fail++; $display("FAIL rx_ovf_status: got %h expected %h", rdat, exp); end
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL rx_ovf_irq: got %b expected 1", irq_o); end
    wr(32'h4, 32'h20, 4'h1);
    exp_q.push_back(32'h0000_0160);
    bus(32'h0, 1'b0, 32'h0, 4'hF, 1'b1, 8'h99, rdat, ack, err);
    exp = exp_q.pop_front();
    n_checks++; if (rdat !== exp) begin n_fail++; $display("FAIL rx_push_pop_read: got %h expected %h", rdat, exp); end
    exp_q.push_back(32'h0010_0006);
    rd(32'h4, rdat, ack);
    exp = exp_q.pop_front();
    n_checks++; if (rdat !== exp) begin n_fail++; $display("FAIL rx_push_pop_status: got %h expected %h", rdat, exp); end
    for (int i = 1; i < 16; i++) exp_q.push_back(32'h0000_0160 + i);
    exp_q.push_back(32'h0000_0199);
    for (int i = 0; i < 16; i++) begin
      rd(32'h0, rdat, ack);
      exp = exp_q.pop_front();
      n_checks++; if (rdat !== exp) begin n_fail++; $display("FAIL rx_drain_%0d: got %h expected %h", i, rdat, exp); end
    end
  endtask

  task automatic test_err;
    wr(32'h8, 32'h0, 4'hF);
    bus(32'h0A, 1'b1, 32'h7, 4'hF, 1'b0, 8'h00, rdat, ack, err);
    n_checks++; if (err !== 1'b1 || ack !== 1'b0 || rdat !== 32'h0) begin n_fail++; $display("FAIL err_adr_0a: err %b ack %b dat %h, expected 1 0 0", err, ack, rdat); end
    bus(32'h18, 1'b1, 32'h7, 4'hF, 1'b0, 8'h00, rdat, ack, err);
    n_checks++; if (err !== 1'b1 || ack !== 1'b0) begin n_fail++; $display("FAIL err_adr_18: err %b ack %b, expected 1 0", err, ack); end
    bus(32'h02, 1'b0, 32'h0, 4'hF, 1'b0, 8'h00, rdat, ack, err);
    n_checks++; if (err !== 1'b1 || ack !== 1'b0) begin n_fail++; $display("FAIL err_adr_02: err %b ack %b, expected 1 0", err, ack); end
    // hold the strobe through the termination cycle: err must last exactly one cycle
    @(negedge clk);
    adr = 32'h10; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (wb_err_o !== 1'b1 || wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL err_adr_10: err %b ack %b, expected 1 0", wb_err_o, wb_ack_o); end
    @(posedge clk); #1;
    n_checks++; if (wb_err_o !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: err %b expected 0", wb_err_o); end
    @(negedge clk); cyc = 1'b0; stb = 1'b0;
    exp_q.push_back(32'h0);
    rd(32'h8, rdat, ack);
    exp = exp_q.pop_front();
    n_checks++; if (rdat !== exp || ack !== 1'b1 || enable_o !== 1'b0) begin n_fail++; $display("FAIL err_no_side_effect: ctrl %h en %b ack %b, expected %h 0 1", rdat, enable_o, ack, exp); end
  endtask

  task automatic test_rx_disabled;
    rx_push(8'h77);
    exp_q.push_back(32'h0000_000A);
    rd(32'h4, rdat, ack);
    exp = exp_q.pop_front();
    n_checks++; if (rdat !== exp) begin n_fail++; $display("FAIL rx_disabled_status: got %h expected %h", rdat, exp); end
  endtask

  task automatic test_irq;
    wr(32'h8, 32'h3, 4'h1);
    @(negedge clk);
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_tx_empty: got %b expected 1", irq_o); end
    wr(32'h8, 32'h5, 4'h1);
    @(negedge clk);
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_rx_idle: got %b expected 0", irq_o); end
    rx_data = 8'h3C; rx_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_lag: got %b expected 0 one cycle after push", irq_o); end
    @(negedge clk); rx_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_rx_data: got %b expected 1", irq_o); end
    exp_q.push_back(32'h0000_013C);
    rd(32'h0, rdat, ack);
    exp = exp_q.pop_front();
    n_checks++; if (rdat !== exp) begin n_fail++; $display("FAIL irq_rx_read: got %h expected %h", rdat, exp); end
    @(posedge clk); #1;
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_rx_cleared: got %b expected 0", irq_o); end
  endtask

  task automatic test_baud;
    wr(32'hC, 32'hFFFF, 4'b0001);
    n_checks++; if (baud_div_o !== 16'h01FF) begin n_fail++; $display("FAIL baud_lane0: got %h expected 01ff", baud_div_o); end
    exp_q.push_back(32'h0000_01FF);
    rd(32'hC, rdat, ack);
    exp = exp_q.pop_front();
    n_checks++; if (rdat !== exp) begin n_fail++; $display("FAIL baud_read: got %h expected %h", rdat, exp); end
    wr(32'hC, 32'hFFFF_AB00, 4'b0010);
    n_checks++; if (baud_div_o !== 16'hABFF) begin n_fail++; $display("FAIL baud_lane1: got %h expected abff", baud_div_o); end
    @(negedge clk);
    adr = 32'hC; we = 1'b1; dat_in = 32'h1234; sel = 4'b0011; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    #1;
    n_checks++; if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin n_fail++; $display("FAIL abort_no_ack: ack %b err %b, expected 0 0", wb_ack_o, wb_err_o); end
    n_checks++; if (baud_div_o !== 16'h1234) begin n_fail++; $display("FAIL abort_side_effect: got %h expected 1234", baud_div_o); end
    @(negedge clk); cyc = 1'b0; we = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_ack[$];
    for (int i = 0; i < 2; i++) begin
      exp_ack.push_back(32'h1); exp_q.push_back(32'h0000_1234);
      exp_ack.push_back(32'h0); exp_q.push_back(32'h0);
    end
    @(negedge clk);
    adr = 32'hC; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp = exp_ack.pop_front();
      n_checks++; if (wb_ack_o !== exp[0]) begin n_fail++; $display("FAIL b2b_ack_%0d: got %b expected %b", i, wb_ack_o, exp[0]); end
      exp = exp_q.pop_front();
      n_checks++; if (wb_dat_o !== exp) begin n_fail++; $display("FAIL b2b_dat_%0d: got %h expected %h", i, wb_dat_o, exp); end
    end
    @(negedge clk); cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic test_reset_mid_access;
    wr(32'h0, 32'hA5, 4'h1);
    @(negedge clk);
    adr = 32'hC; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_pre_ack: got %b expected 1", wb_ack_o); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL mid_reset_ack: ack %b dat %h, expected 0 0", wb_ack_o, wb_dat_o); end
    n_checks++; if (tx_valid_o !== 1'b0 || tx_data_o !== 8'h00 || enable_o !== 1'b0 || irq_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_outputs: valid %b data %h en %b irq %b, expected 0 00 0 0", tx_valid_o, tx_data_o, enable_o, irq_o); end
    @(negedge clk); cyc = 1'b0; stb = 1'b0;
    @(negedge clk); rst = 1'b0;
    exp_q.push_back(32'd434);
    exp_q.push_back(32'h0000_000A);
    exp_q.push_back(32'h0);
    rd(32'hC, rdat, ack);
    exp = exp_q.pop_front();
    n_checks++; if (rdat !== exp) begin n_fail++; $display("FAIL mid_reset_baud: got %h expected %h", rdat, exp); end
    rd(32'h4, rdat, ack);
    exp = exp_q.pop_front();
    n_checks++; if (rdat !== exp) begin n_fail++; $display("FAIL mid_reset_status: got %h expected %h", rdat, exp); end
    rd(32'h8, rdat, ack);
    exp = exp_q.pop_front();
    n_checks++; if (rdat !== exp) begin n_fail++; $display("FAIL mid_reset_ctrl: got %h expected %h", rdat, exp); end
  endtask

  initial begin
    test_reset;
    test_tx_stream;
    test_tx_overflow;
    test_rx;
    test_err;
    test_rx_disabled;
    test_irq;
    test_baud;
    test_back_to_back;
    test_reset_mid_access;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
